// File: rtl/mac_gate_seq_pkg.sv
// Shared widths and FSM encoding for the zero-gated MAC sequencer.
package mac_gate_seq_pkg;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int LEN_BW  = 4;
    localparam int STAT_BW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_gate_seq_if.sv
// Control, operand feed and result handshake bundle of the MAC sequencer.
interface mac_gate_seq_if
    import mac_gate_seq_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW,
    parameter int len_bw  = LEN_BW,
    parameter int stat_bw = STAT_BW
);
    logic                start;
    logic [len_bw-1:0]   len_cfg;
    logic                in_valid;
    logic                in_ready;
    logic [bw-1:0]       a_in;
    logic [bw-1:0]       w_in;
    logic                out_valid;
    logic                out_ready;
    logic [psum_bw-1:0]  out_psum;
    logic                busy;
    logic                clr_stats;
    logic [stat_bw-1:0]  skip_cnt;

    modport master (
        output start, len_cfg, in_valid, a_in, w_in, out_ready, clr_stats,
        input  in_ready, out_valid, out_psum, busy, skip_cnt
    );

    modport slave (
        input  start, len_cfg, in_valid, a_in, w_in, out_ready, clr_stats,
        output in_ready, out_valid, out_psum, busy, skip_cnt
    );
endinterface

// File: rtl/mac_gate_seq_mac.sv
// Zero-gated MAC datapath: out = (sum_term_zero ? 0 : c) + (product_term_zero ? 0 : a*b), purely combinational.
// Unsigned a, signed b; assumes psum_bw > 2*bw so the product always fits before sign extension.
module mac_gate_seq_mac
    import mac_gate_seq_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW
) (
    input  logic [bw-1:0]              a,
    input  logic signed [bw-1:0]       b,
    input  logic signed [psum_bw-1:0]  c,
    input  logic                       product_term_zero,
    input  logic                       sum_term_zero,
    output logic signed [psum_bw-1:0]  out
);
    logic signed [2*bw:0]       a_ext;
    logic signed [2*bw:0]       b_ext;
    logic signed [2*bw:0]       prod;
    logic signed [psum_bw-1:0]  prod_ext;
    logic signed [psum_bw-1:0]  addend;

    always_comb begin
        // Operands are isolated to zero when gated so the multiplier does not toggle.
        a_ext    = '0;
        b_ext    = '0;
        if (!product_term_zero) begin
            a_ext = {{(bw+1){1'b0}}, a};
            b_ext = {{(bw+1){b[bw-1]}}, b};
        end
        prod     = a_ext * b_ext;
        prod_ext = {{(psum_bw-2*bw-1){prod[2*bw]}}, prod};
        addend   = sum_term_zero ? '0 : c;
        out      = addend + prod_ext;
    end
endmodule

// File: rtl/mac_gate_seq.sv
// Sequences a zero-gated MAC over a programmed-length dot product; result valid 1 cycle after last accept.
// in_ready only in ACC; result held in DONE until out_ready; gated-multiply count saturates.
module mac_gate_seq
    import mac_gate_seq_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW,
    parameter int len_bw  = LEN_BW,
    parameter int stat_bw = STAT_BW
) (
    input  logic          clk,
    input  logic          reset,
    mac_gate_seq_if.slave bus
);
    state_t                     state_q;
    state_t                     state_d;
    logic [len_bw-1:0]          len_q;
    logic [len_bw-1:0]          term_idx;
    logic signed [psum_bw-1:0]  psum_q;
    logic signed [psum_bw-1:0]  psum_next;
    logic [stat_bw-1:0]         skip_q;

    logic accept;
    logic prod_zero;
    logic first;
    logic last;
    logic start_ok;

    assign start_ok  = (state_q == IDLE) && bus.start && (bus.len_cfg != '0);
    assign accept    = bus.in_valid && (state_q == ACC);
    assign first     = (term_idx == '0);
    assign last      = ((term_idx + len_bw'(1)) == len_q);
    // With no accepted term the multiplier is held gated.
    assign prod_zero = !accept || (bus.a_in == '0) || (bus.w_in == '0);

    mac_gate_seq_mac #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) u_mac (
        .a                 (bus.a_in),
        .b                 (bus.w_in),
        .c                 (psum_q),
        .product_term_zero (prod_zero),
        .sum_term_zero     (first),
        .out               (psum_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (accept && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            term_idx <= '0;
            psum_q   <= '0;
        end else begin
            if (start_ok) begin
                len_q    <= bus.len_cfg;
                term_idx <= '0;
            end
            if (accept) begin
                psum_q   <= psum_next;
                term_idx <= term_idx + len_bw'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clr_stats) begin
            skip_q <= '0;
        end else if (accept && prod_zero && (skip_q != '1)) begin
            skip_q <= skip_q + stat_bw'(1);
        end
    end

    assign bus.out_psum = psum_q;
    assign bus.skip_cnt = skip_q;

endmodule

// File: tb/tb_mac_gate_seq.sv
// Directed and randomized checks of mac_gate_seq against an integer dot-product model.
module tb_mac_gate_seq;
    import mac_gate_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_gate_seq_if bus ();

    mac_gate_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int exp_sum  = 0;
    int exp_skip = 0;
    int n_terms  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Called at a negedge in IDLE; leaves the DUT in ACC at the next negedge.
    task automatic begin_run(input int len);
        bus.start   = 1'b1;
        bus.len_cfg = 4'(len);
        @(negedge clk);
        bus.start   = 1'b0;
        exp_sum     = 0;
        n_terms     = 0;
        chk("in_ready_after_start", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] w, input int gap, input logic clr = 1'b0);
        int av;
        int wv;
        av = int'(a);
        wv = int'($signed(w));
        bus.in_valid = 1'b0;
        if (gap > 0) begin
            #1;
            chk("bubble_mult_gated", {31'b0, dut.prod_zero}, 32'd1);
            repeat (gap) @(negedge clk);
        end
        bus.in_valid  = 1'b1;
        bus.a_in      = a;
        bus.w_in      = w;
        bus.clr_stats = clr;
        #1;
        chk("in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("prod_zero_gate", {31'b0, dut.prod_zero}, {31'b0, (av == 0) || (wv == 0)});
        chk("sum_term_gate", {31'b0, dut.first}, {31'b0, n_terms == 0});
        exp_sum = exp_sum + av * wv;
        n_terms++;
        if (clr) exp_skip = 0;
        else if ((av == 0) || (wv == 0)) exp_skip = (exp_skip >= 65535) ? 65535 : exp_skip + 1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.clr_stats = 1'b0;
    endtask

    // Called at the negedge right after the final accept.
    task automatic finish_run(input int stall);
        logic [31:0] want;
        want = 32'(exp_sum) & 32'h0000_FFFF;
        chk("out_valid_latency", {31'b0, bus.out_valid}, 32'd1);
        chk("in_ready_done", {31'b0, bus.in_ready}, 32'd0);
        chk("out_psum", {16'b0, bus.out_psum}, want);
        chk("skip_cnt", {16'b0, bus.skip_cnt}, 32'(exp_skip));
        bus.out_ready = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("stall_out_psum", {16'b0, bus.out_psum}, want);
            chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len_cfg   = 4'd3;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("idle_busy", {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        int len;
        logic [3:0] ra;
        logic [3:0] rw;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.len_cfg   = '0;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.w_in      = '0;
        bus.out_ready = 1'b0;
        bus.clr_stats = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_out_psum", {16'b0, bus.out_psum}, 32'd0);
        chk("rst_skip_cnt", {16'b0, bus.skip_cnt}, 32'd0);

        // Basic dot product: 6 - 1 + 8 = 13
        begin_run(3);
        send(4'd2, 4'd3, 0);
        send(4'd1, 4'hF, 0);
        send(4'd4, 4'd2, 0);
        chk("basic_model", 32'(exp_sum), 32'd13);
        finish_run(0);

        // Zero gating: only (7,-2) contributes
        begin_run(4);
        send(4'd0, 4'd5, 0);
        send(4'd3, 4'd0, 0);
        send(4'd0, 4'd0, 0);
        send(4'd7, 4'hE, 0);
        finish_run(0);

        // Bubbles between terms and a 5-cycle output stall
        begin_run(3);
        send(4'd2, 4'd3, 2);
        send(4'd1, 4'hF, 1);
        send(4'd4, 4'd2, 3);
        finish_run(5);

        // Zero length start is ignored
        bus.start   = 1'b1;
        bus.len_cfg = 4'd0;
        @(negedge clk);
        bus.start   = 1'b0;
        chk("len0_busy", {31'b0, bus.busy}, 32'd0);
        chk("len0_in_ready", {31'b0, bus.in_ready}, 32'd0);

        // Start during ACC does not relatch length
        begin_run(2);
        send(4'd3, 4'd3, 0);
        bus.start   = 1'b1;
        bus.len_cfg = 4'd9;
        send(4'd1, 4'd2, 0);
        bus.start   = 1'b0;
        finish_run(0);

        // Full-length run: 15 * 105 = 1575
        begin_run(15);
        for (int i = 0; i < 15; i++) send(4'd15, 4'd7, 0);
        finish_run(1);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            len = int'($urandom_range(1, 15));
            begin_run(len);
            for (int t = 0; t < len; t++) begin
                ra = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                rw = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                send(ra, rw, int'($urandom_range(0, 2)));
            end
            finish_run(int'($urandom_range(0, 2)));
        end

        // Drive skip_cnt to full scale with continuous zero-term runs
        bus.clr_stats = 1'b1;
        @(negedge clk);
        bus.clr_stats = 1'b0;
        exp_skip = 0;
        chk("clr_stats", {16'b0, bus.skip_cnt}, 32'd0);
        bus.start     = 1'b1;
        bus.len_cfg   = 4'd15;
        bus.in_valid  = 1'b1;
        bus.a_in      = 4'd0;
        bus.w_in      = 4'd5;
        bus.out_ready = 1'b1;
        repeat (4369 * 17) @(negedge clk);
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        exp_skip = 4369 * 15;
        chk("preload_skip", {16'b0, bus.skip_cnt}, 32'(exp_skip));
        chk("preload_busy", {31'b0, bus.busy}, 32'd0);
        begin_run(1);
        send(4'd0, 4'd2, 0);
        chk("skip_saturated", {16'b0, bus.skip_cnt}, 32'hFFFF);
        finish_run(0);

        // Clear coinciding with a counting event
        begin_run(2);
        send(4'd0, 4'd3, 0, 1'b1);
        chk("clr_wins", {16'b0, bus.skip_cnt}, 32'd0);
        send(4'd0, 4'd1, 0);
        finish_run(0);

        // Reset in the middle of a run
        begin_run(4);
        send(4'd0, 4'd1, 0);
        send(4'd2, 4'd2, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_skip = 0;
        chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("mid_rst_skip", {16'b0, bus.skip_cnt}, 32'd0);
        begin_run(1);
        send(4'd5, 4'd5, 0);
        finish_run(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_gate_seq.md
Name: mac_gate_seq

Overview:
Sequencer for a single zero-gated MAC datapath. It accepts a stream of (activation, weight) pairs over a valid/ready handshake and drives the MAC's gating controls: the multiplier is bypassed when either operand is zero, and the adder is bypassed on the first term. It accumulates a dot product of a programmed length and presents the result over an output valid/ready handshake. It also keeps a saturating count of gated multiplies for power-gating statistics. It sits between the activation/weight feed (L0/weight buffers) and the PSUM/OFIFO write side of a corelet.

Parameters:
bw, 4, activation/weight width; activation is unsigned, weight is two's-complement
psum_bw, 16, accumulator/result width, signed
len_bw, 4, width of the dot-product length field; maximum length is 2^len_bw-1
stat_bw, 16, width of the gated-multiply statistics counter

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a new dot product; honoured only in IDLE
len_cfg  in  len_bw  number of terms; sampled when start is honoured
in_valid  in  1  a_in/w_in valid
in_ready  out  1  sequencer accepts a term this cycle
a_in  in  bw  activation, unsigned
w_in  in  bw  weight, signed
out_valid  out  1  out_psum holds the completed dot product
out_ready  in  1  consumer accepts out_psum
out_psum  out  psum_bw  result, signed
busy  out  1  high in ACC or DONE
clr_stats  in  1  clears skip_cnt
skip_cnt  out  stat_bw  saturating count of accepted terms with gated multiplier

Behaviour:
- Reset (synchronous, active-high, clk edge): state=IDLE; in_ready=0, out_valid=0, busy=0, out_psum=0, skip_cnt=0; psum register, term counter and latched length cleared. A reset in ACC or DONE abandons the operation; no partial result is emitted.
- States: IDLE, ACC, DONE. Outputs are Moore: in_ready=(state==ACC), out_valid=(state==DONE), busy=(state!=IDLE).
- IDLE: if start=1 and len_cfg!=0, latch len_cfg, term_idx=0, then go to ACC. start with len_cfg=0 is ignored (stay IDLE). start in ACC or DONE is ignored.
- ACC: a term is accepted on a cycle with in_valid=1 and in_ready=1. For an accepted term:
  - prod_zero=(a_in==0)||(w_in==0)
  - first=(term_idx==0)
  - product = zero-extended a_in × signed w_in, forced to 0 when prod_zero (multiplier not exercised)
  - psum_next = product when first (adder bypassed); otherwise psum_q + product
  - psum_q <= psum_next; term_idx++
- Arithmetic is signed and wraps modulo 2^psum_bw, with no saturation.
- No accept (in_valid=0) leaves psum_q, term_idx and skip_cnt unchanged. Bubbles are allowed anywhere in the stream.
- Accepting term index len-1 moves to DONE on the same edge. out_valid rises the cycle after the final accept, with out_psum=psum_q (latency 1). in_ready=0 in DONE.
- DONE: out_psum is held stable while out_valid=1 and out_ready=0. When out_valid=1 and out_ready=1, go to IDLE; out_valid=0 on the next cycle. A start on that same handshake cycle is ignored; a new start is honoured only in IDLE.
- skip_cnt: increments on each accepted term with prod_zero=1 and saturates at 2^stat_bw-1. It is not cleared by start.
- clr_stats: skip_cnt=0 on the next edge. When clr_stats coincides with a counting event, the clear wins and the result is 0.
- The mac gating inputs are driven combinationally from the current accepted term. When no term is accepted, product_term_zero=1 so the multiplier stays idle.

Decomposition:
- Shared package holds the state encoding (IDLE=2'd0, ACC=2'd1, DONE=2'd2) and the default widths (BW=4, PSUM_BW=16).
- One sub-module: the existing mac datapath is instantiated as the arithmetic core.
  - a = a_in, b = w_in, c = psum_q
  - product_term_zero = prod_zero
  - sum_term_zero = first
- The sequencer owns only the FSM, the counters and the psum register.

Test Plan:
- Basic dot product: start with len_cfg=3; terms (2,3),(1,-1),(4,2) back-to-back → out_valid one cycle after the third accept, out_psum=13, skip_cnt=0.
- Zero gating: len_cfg=4; terms (0,5),(3,0),(0,0),(7,-2) → out_psum=-14, skip_cnt=3. The gating inputs are high on the first three accepts; sum-term gating is high on the first accept only.
- Handshake stalls:
  - in_valid bubbles between terms → same result as back-to-back.
  - out_ready held low 5 cycles → out_psum stable, in_ready=0; IDLE one cycle after out_ready=1.
- Ignored requests:
  - start with len_cfg=0 → stays IDLE.
  - start pulsed during ACC → len_cfg unchanged, term count unaffected.
- Wrap and saturation:
  - psum_bw=16, len_cfg=15; terms (15,7)×15 → out_psum=1575.
  - Preload skip_cnt to 0xFFFF using zero terms → stays 0xFFFF.
  - clr_stats coinciding with a zero term → 0.
- Reset mid-operation: reset after 2 of 4 terms → next cycle IDLE, busy=0, out_valid=0, skip_cnt=0. A fresh len_cfg=1 run with (5,5) → out_psum=25.
